// File: rtl/cve2_pkg.sv
// Shared types for the cve2 memory arbiter: requester IDs and arbitration states.
package cve2_pkg;

    typedef enum logic {
        ARB_SRC_INSTR = 1'b0,
        ARB_SRC_DATA  = 1'b1
    } arb_src_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD_I,
        ARB_HOLD_D
    } arb_state_e;

    localparam logic [3:0] ARB_INSTR_BE = 4'hF;

endpackage

// File: rtl/cve2_mem_arb_id_fifo.sv
// Source-ID FIFO tracking granted-but-unanswered transactions, oldest at the head.
module cve2_mem_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_cnt == CntW'(Depth));
    assign empty_o   = (r_cnt == '0);
    assign head_o    = r_mem[r_rptr];
    // A simultaneous pop frees the head slot, so a push is accepted even when full.
    assign w_do_push = push_i & (~full_o | pop_i);
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + PtrW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/cve2_mem_arbiter.sv
// Arbitrates cve2 instruction-fetch and LSU ports onto one req/gnt/rvalid memory port.
// Define CVE2_MEM_ARB_RR_EN for round-robin; otherwise data has fixed priority.
module cve2_mem_arbiter
    import cve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        resp_unexpected_o
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    arb_src_e   w_winner;
    arb_src_e   w_head;
    logic [0:0] w_head_raw;
    logic       w_winner_req;
    logic       w_grant;
    logic       w_pop;
    logic       w_fifo_full;
    logic       w_fifo_empty;

`ifdef CVE2_MEM_ARB_RR_EN
    arb_src_e r_last;

    // Remembers the most recently granted port; the other port wins the next tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= ARB_SRC_INSTR;
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end
`endif

    always_comb begin
        w_winner = ARB_SRC_INSTR;
        case (r_state)
            ARB_HOLD_I: w_winner = ARB_SRC_INSTR;
            ARB_HOLD_D: w_winner = ARB_SRC_DATA;
            default: begin
`ifdef CVE2_MEM_ARB_RR_EN
                if (instr_req_i && data_req_i) begin
                    w_winner = (r_last == ARB_SRC_INSTR) ? ARB_SRC_DATA : ARB_SRC_INSTR;
                end else if (data_req_i) begin
                    w_winner = ARB_SRC_DATA;
                end
`else
                if (data_req_i) begin
                    w_winner = ARB_SRC_DATA;
                end
`endif
            end
        endcase
    end

    assign w_winner_req = (w_winner == ARB_SRC_DATA) ? data_req_i : instr_req_i;
    assign mem_req_o    = w_winner_req & ~w_fifo_full & ~rst_i;
    assign w_grant      = mem_req_o & mem_gnt_i;
    assign instr_gnt_o  = w_grant & (w_winner == ARB_SRC_INSTR);
    assign data_gnt_o   = w_grant & (w_winner == ARB_SRC_DATA);

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = ARB_INSTR_BE;
        mem_wdata_o = '0;
        if (w_winner == ARB_SRC_DATA) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving HOLD waits for a real grant, so a dropped request keeps the lock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    w_state_nxt = (w_winner == ARB_SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
                end
            end
            ARB_HOLD_I, ARB_HOLD_D: begin
                if (w_grant) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    cve2_mem_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_winner),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .head_o  (w_head_raw)
    );

    assign w_head = arb_src_e'(w_head_raw);

    assign w_pop             = mem_rvalid_i & ~w_fifo_empty & ~rst_i;
    assign resp_unexpected_o = mem_rvalid_i & w_fifo_empty & ~rst_i;
    assign instr_rvalid_o    = w_pop & (w_head == ARB_SRC_INSTR);
    assign data_rvalid_o     = w_pop & (w_head == ARB_SRC_DATA);
    assign instr_rdata_o     = mem_rdata_i;
    assign data_rdata_o      = mem_rdata_i;
    assign instr_err_o       = mem_err_i;
    assign data_err_o        = mem_err_i;

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Self-checking bench for cve2_mem_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_cve2_mem_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        resp_unexpected_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: queue of outstanding sources (1 = data), lock on an ungranted winner, last granted.
    bit mq[$];
    bit m_lock     = 1'b0;
    bit m_lock_src = 1'b0;
    bit m_last     = 1'b0;

    always #5 clk = ~clk;

    cve2_mem_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .resp_unexpected_o(resp_unexpected_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst, input bit ireq, input logic [31:0] iaddr,
                        input bit dreq, input bit dwe, input logic [3:0] dbe,
                        input logic [31:0] daddr, input logic [31:0] dwd,
                        input bit mgnt, input bit mrv, input logic [31:0] mrd, input bit merr);
        bit w, wreq, e_req, e_gnt, pop, unexp, head;
        rst_i = rst; instr_req_i = ireq; instr_addr_i = iaddr;
        data_req_i = dreq; data_we_i = dwe; data_be_i = dbe; data_addr_i = daddr;
        data_wdata_i = dwd; mem_gnt_i = mgnt; mem_rvalid_i = mrv;
        mem_rdata_i = mrd; mem_err_i = merr;

        if (m_lock) w = m_lock_src;
        else if (ireq && dreq) begin
`ifdef CVE2_MEM_ARB_RR_EN
            w = ~m_last;
`else
            w = 1'b1;
`endif
        end else w = dreq;
        wreq  = w ? dreq : ireq;
        e_req = wreq && (mq.size() < MAXO) && !rst;
        e_gnt = e_req && mgnt;
        pop   = mrv && (mq.size() > 0) && !rst;
        unexp = mrv && (mq.size() == 0) && !rst;
        head  = (mq.size() > 0) ? mq[0] : 1'b0;

        #2;
        chk("mem_req", {31'b0, mem_req_o}, {31'b0, e_req});
        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, e_gnt && !w});
        chk("data_gnt", {31'b0, data_gnt_o}, {31'b0, e_gnt && w});
        chk("mem_addr", mem_addr_o, w ? daddr : iaddr);
        chk("mem_we", {31'b0, mem_we_o}, {31'b0, w ? dwe : 1'b0});
        chk("mem_be", {28'b0, mem_be_o}, {28'b0, w ? dbe : 4'hF});
        chk("mem_wdata", mem_wdata_o, w ? dwd : 32'h0);
        chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, pop && !head});
        chk("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, pop && head});
        chk("resp_unexpected", {31'b0, resp_unexpected_o}, {31'b0, unexp});
        chk("instr_rdata", instr_rdata_o, mrd);
        chk("data_rdata", data_rdata_o, mrd);
        chk("instr_err", {31'b0, instr_err_o}, {31'b0, merr});
        chk("data_err", {31'b0, data_err_o}, {31'b0, merr});

        if (rst) begin
            mq.delete();
            m_lock = 1'b0;
            m_last = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (e_gnt) begin
                mq.push_back(w);
                m_last = w;
                m_lock = 1'b0;
            end else if (e_req) begin
                m_lock     = 1'b1;
                m_lock_src = w;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; data_req_i = 1'b0;
        data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        @(posedge clk);
        #1;

        // Requests and rvalid under reset are all suppressed.
        step(1, 1, 32'h10, 1, 1, 4'h3, 32'h20, 32'h55, 1, 1, 32'h1234, 0);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

        // Both ports requesting with a granting memory, responses draining each cycle.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h100 + i, 1, 0, 4'hF, 32'h200 + i, 32'h0, 1, mq.size() > 0, 32'hA0 + i, 0);
        end
        while (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB0, 0);

        // Stalled data request stays locked while instr arrives; granted in cycle 4.
        step(0, 0, 32'h300, 1, 1, 4'h5, 32'h400, 32'hCAFE, 0, 0, 0, 0);
        step(0, 1, 32'h300, 1, 1, 4'h5, 32'h400, 32'hCAFE, 0, 0, 0, 0);
        step(0, 1, 32'h300, 1, 1, 4'h5, 32'h400, 32'hCAFE, 0, 0, 0, 0);
        step(0, 1, 32'h300, 1, 1, 4'h5, 32'h400, 32'hCAFE, 1, 0, 0, 0);
        step(0, 1, 32'h300, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0);

        // FIFO now full: request blocked; pop then grant+pop keep occupancy; refill blocks again.
        step(0, 1, 32'h500, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 1, 32'h500, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h1, 0);
        step(0, 1, 32'h504, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h2, 0);
        step(0, 1, 32'h508, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 1, 32'h50C, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        while (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC0, 0);

        // In-order response routing: I then D, data read returns DEADBEEF.
        step(0, 1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0, 1, 0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h1111_2222, 0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);

        // Reset with one outstanding: the late response is flagged unexpected.
        step(0, 1, 32'h600, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h77, 0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);

        // Error on a data response.
        step(0, 0, 32'h0, 1, 1, 4'hC, 32'h700, 32'h99, 1, 0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1);

        // Random traffic; the locked requester keeps its request up until granted.
        for (int i = 0; i < 500; i++) begin
            bit ir, dr, rv;
            ir = ($urandom_range(0, 9) < 6);
            dr = ($urandom_range(0, 9) < 6);
            if (m_lock && !m_lock_src) ir = 1'b1;
            if (m_lock && m_lock_src) dr = 1'b1;
            rv = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 49) == 0, ir, $urandom, dr, $urandom_range(0, 1) == 1,
                 4'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 6, rv,
                 $urandom, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
